// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: ALU op codes, forward selects
// and the ID/EX register bundle.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int OP_W   = 3;

    typedef logic [OP_W-1:0]   alu_op_t;
    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam alu_op_t ALU_ADD = 3'b000;
    localparam alu_op_t ALU_SUB = 3'b001;
    localparam alu_op_t ALU_OR  = 3'b010;
    localparam alu_op_t ALU_SLT = 3'b011;
    localparam alu_op_t ALU_AND = 3'b100;
    localparam alu_op_t ALU_XOR = 3'b101;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic     valid;
        alu_op_t  aluOp;
        reg_idx_t rs;
        reg_idx_t rt;
        reg_idx_t rd;
        word_t    rsData;
        word_t    rtData;
        word_t    imm;
        logic     aluSrc;
        logic     regWrite;
        logic     memRead;
        logic     memWrite;
        logic     memToReg;
    } id_ex_t;

    // Younger producer (EX/MEM) shadows the older one; r0 never forwards.
    function automatic fwd_sel_t fwd_pick(
        input reg_idx_t src,
        input logic     em_we,
        input reg_idx_t em_rd,
        input logic     mw_we,
        input reg_idx_t mw_rd
    );
        fwd_sel_t sel;
        sel = FWD_REG;
        if (em_we && em_rd != '0 && em_rd == src)
            sel = FWD_EXMEM;
        else if (mw_we && mw_rd != '0 && mw_rd == src)
            sel = FWD_MEMWB;
        return sel;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: ID fields, later-stage writeback
// taps, and the EX-side operand/control outputs.
interface id_ex_stage_if;
    import mips_pkg::*;

    logic     id_valid;
    alu_op_t  id_aluOp;
    reg_idx_t id_rs;
    reg_idx_t id_rt;
    reg_idx_t id_rd;
    word_t    id_rsData;
    word_t    id_rtData;
    word_t    id_imm;
    logic     id_aluSrc;
    logic     id_regWrite;
    logic     id_memRead;
    logic     id_memWrite;
    logic     id_memToReg;
    logic     flush;

    logic     exmem_regWrite;
    reg_idx_t exmem_rd;
    word_t    exmem_result;
    logic     memwb_regWrite;
    reg_idx_t memwb_rd;
    word_t    memwb_data;

    logic     stall;
    logic     ex_valid;
    alu_op_t  aluOp;
    word_t    data1;
    word_t    data2;
    word_t    ex_storeData;
    reg_idx_t ex_rd;
    logic     ex_regWrite;
    logic     ex_memRead;
    logic     ex_memWrite;
    logic     ex_memToReg;

    modport master (
        output id_valid, id_aluOp, id_rs, id_rt, id_rd,
        output id_rsData, id_rtData, id_imm, id_aluSrc,
        output id_regWrite, id_memRead, id_memWrite,
        output id_memToReg, flush,
        output exmem_regWrite, exmem_rd, exmem_result,
        output memwb_regWrite, memwb_rd, memwb_data,
        input  stall, ex_valid, aluOp, data1, data2,
        input  ex_storeData, ex_rd, ex_regWrite,
        input  ex_memRead, ex_memWrite, ex_memToReg
    );

    modport slave (
        input  id_valid, id_aluOp, id_rs, id_rt, id_rd,
        input  id_rsData, id_rtData, id_imm, id_aluSrc,
        input  id_regWrite, id_memRead, id_memWrite,
        input  id_memToReg, flush,
        input  exmem_regWrite, exmem_rd, exmem_result,
        input  memwb_regWrite, memwb_rd, memwb_data,
        output stall, ex_valid, aluOp, data1, data2,
        output ex_storeData, ex_rd, ex_regWrite,
        output ex_memRead, ex_memWrite, ex_memToReg
    );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forward-select generation for the EX stage
// source registers.
module fwd_unit
    import mips_pkg::*;
(
    input  reg_idx_t i_ex_rs,
    input  reg_idx_t i_ex_rt,
    input  logic     i_exmem_we,
    input  reg_idx_t i_exmem_rd,
    input  logic     i_memwb_we,
    input  reg_idx_t i_memwb_rd,
    output fwd_sel_t o_fwd_a,
    output fwd_sel_t o_fwd_b
);

    assign o_fwd_a = fwd_pick(i_ex_rs,
                              i_exmem_we, i_exmem_rd,
                              i_memwb_we, i_memwb_rd);

    assign o_fwd_b = fwd_pick(i_ex_rt,
                              i_exmem_we, i_exmem_rd,
                              i_memwb_we, i_memwb_rd);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubble
// and EX operand forwarding.
module id_ex_stage
    import mips_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);

    id_ex_t   r_ex;
    id_ex_t   w_nxt;
    logic     w_haz;
    logic     w_bubble;
    fwd_sel_t w_fwd_a;
    fwd_sel_t w_fwd_b;
    word_t    w_opa;
    word_t    w_opb;

    assign w_haz = r_ex.valid & r_ex.memRead
                 & (r_ex.rd != '0) & bus.id_valid
                 & ((r_ex.rd == bus.id_rs)
                  | (r_ex.rd == bus.id_rt));

    assign w_bubble  = bus.flush | w_haz;
    assign bus.stall = w_haz & ~bus.flush;

    always_comb begin
        w_nxt = '0;
        if (!w_bubble) begin
            w_nxt.valid    = bus.id_valid;
            w_nxt.aluOp    = bus.id_aluOp;
            w_nxt.rs       = bus.id_rs;
            w_nxt.rt       = bus.id_rt;
            w_nxt.rd       = bus.id_rd;
            w_nxt.rsData   = bus.id_rsData;
            w_nxt.rtData   = bus.id_rtData;
            w_nxt.imm      = bus.id_imm;
            w_nxt.aluSrc   = bus.id_aluSrc;
            w_nxt.regWrite = bus.id_regWrite & bus.id_valid;
            w_nxt.memRead  = bus.id_memRead  & bus.id_valid;
            w_nxt.memWrite = bus.id_memWrite & bus.id_valid;
            w_nxt.memToReg = bus.id_memToReg & bus.id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ex <= '0;
        else
            r_ex <= w_nxt;
    end

    fwd_unit u_fwd (
        .i_ex_rs    (r_ex.rs),
        .i_ex_rt    (r_ex.rt),
        .i_exmem_we (bus.exmem_regWrite),
        .i_exmem_rd (bus.exmem_rd),
        .i_memwb_we (bus.memwb_regWrite),
        .i_memwb_rd (bus.memwb_rd),
        .o_fwd_a    (w_fwd_a),
        .o_fwd_b    (w_fwd_b)
    );

    always_comb begin
        case (w_fwd_a)
            FWD_EXMEM: w_opa = bus.exmem_result;
            FWD_MEMWB: w_opa = bus.memwb_data;
            default:   w_opa = r_ex.rsData;
        endcase
    end

    always_comb begin
        case (w_fwd_b)
            FWD_EXMEM: w_opb = bus.exmem_result;
            FWD_MEMWB: w_opb = bus.memwb_data;
            default:   w_opb = r_ex.rtData;
        endcase
    end

    assign bus.data1        = w_opa;
    assign bus.data2        = r_ex.aluSrc ? r_ex.imm : w_opb;
    assign bus.ex_storeData = w_opb;
    assign bus.ex_valid     = r_ex.valid;
    assign bus.aluOp        = r_ex.aluOp;
    assign bus.ex_rd        = r_ex.rd;
    assign bus.ex_regWrite  = r_ex.regWrite;
    assign bus.ex_memRead   = r_ex.memRead;
    assign bus.ex_memWrite  = r_ex.memWrite;
    assign bus.ex_memToReg  = r_ex.memToReg;

endmodule
